// File: rtl/usec_delay_timer.sv
// usec_delay_timer
// One-shot microsecond delay timer. A load strobe captures a delay count in
// microseconds. A prescaler divides clk down to a 1 us tick, and each tick
// decrements the count. When the count reaches zero the block raises a level
// interrupt. The interrupt stays high until the CPU acknowledges it or
// reloads the timer.
//
// Parameters:
//   BITS            width of the delay count / value
//   MHZ_TIMER_BITS  width of the prescaler counter
//   MHZ_TIMER_VALUE clk cycles per 1 us tick (1 .. 2**MHZ_TIMER_BITS)
//
// Ports:
//   clk             system clock, rising edge
//   reset           synchronous active-high reset, highest priority
//   nwr             active-low load strobe; the last low edge starts timing
//   value           delay in us, captured while nwr = 0
//   interrupt_clear active-high level acknowledge
//   interrupt       registered pending-expiry flag
module usec_delay_timer #(
   parameter int BITS            = 16,
   parameter int MHZ_TIMER_BITS  = 4,
   parameter int MHZ_TIMER_VALUE = 12
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            nwr,
   input  logic [BITS-1:0] value,
   input  logic            interrupt_clear,
   output logic            interrupt
);

   // Terminal prescaler value. MHZ_TIMER_VALUE may equal 2**MHZ_TIMER_BITS,
   // so only the value minus one is guaranteed to fit the counter.
   localparam logic [MHZ_TIMER_BITS-1:0] PRESC_LAST =
      MHZ_TIMER_BITS'(MHZ_TIMER_VALUE - 1);

   logic [BITS-1:0]           count;
   logic [MHZ_TIMER_BITS-1:0] presc;
   logic                      irq;

   logic running;
   logic tick;
   logic expire;

   assign running = (count != '0);
   assign tick    = running && (presc == PRESC_LAST);
   // The last tick of a delay is the expiry event.
   assign expire  = tick && (count == BITS'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         presc <= '0;
         irq   <= 1'b0;
      end else if (!nwr) begin
         // A load restarts from scratch, even if a delay is in flight,
         // and drops any interrupt that is still pending.
         count <= value;
         presc <= '0;
         irq   <= 1'b0;
      end else begin
         if (!running) begin
            presc <= '0;
         end else if (tick) begin
            presc <= '0;
            count <= count - BITS'(1);
         end else begin
            presc <= presc + MHZ_TIMER_BITS'(1);
         end

         // Expiry wins over a same-edge acknowledge so no event is lost.
         if (expire)
            irq <= 1'b1;
         else if (interrupt_clear)
            irq <= 1'b0;
      end
   end

   assign interrupt = irq;

endmodule

// File: tb/tb_usec_delay_timer.sv
// Bench for usec_delay_timer. Two instances share one stimulus stream:
// u4 runs with a 4-cycle tick and u1 runs with a 1-cycle tick. Expected
// latencies and levels are pushed to a scoreboard when stimulus is driven.
// They are popped and compared when the DUT result is observed.
module tb_usec_delay_timer;

   logic        clk = 1'b0;
   logic        reset;
   logic        nwr;
   logic [15:0] value;
   logic        interrupt_clear;
   logic        irq4;
   logic        irq1;
   int          cyc = 0;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string tag;
      int    val;
   } exp_t;
   exp_t sb[$];

   usec_delay_timer #(.BITS(16), .MHZ_TIMER_BITS(4), .MHZ_TIMER_VALUE(4)) u4 (
      .clk(clk), .reset(reset), .nwr(nwr), .value(value),
      .interrupt_clear(interrupt_clear), .interrupt(irq4)
   );

   usec_delay_timer #(.BITS(16), .MHZ_TIMER_BITS(4), .MHZ_TIMER_VALUE(1)) u1 (
      .clk(clk), .reset(reset), .nwr(nwr), .value(value),
      .interrupt_clear(interrupt_clear), .interrupt(irq1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic irq_of(input bit sel);
      return sel ? irq1 : irq4;
   endfunction

   task automatic expect_val(input string tag, input int v);
      sb.push_back('{tag, v});
   endtask

   task automatic check_next(input int obs);
      exp_t e;
      e = sb.pop_front();
      tests++;
      assert (obs === e.val) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
   endtask

   // Drive nwr low with value v for k edges. e0 is the cycle count of the
   // last low edge. The task is entered and exits just after a negedge.
   task automatic load(input logic [15:0] v, input int k, output int e0);
      nwr   = 1'b0;
      value = v;
      repeat (k) @(negedge clk);
      nwr = 1'b1;
      e0  = cyc;
   endtask

   // Latency, in edges after e0, of the first edge that shows the interrupt
   // high. The result is -1 if the bound expires first.
   task automatic wait_rise(input bit sel, input int e0, input int bound, output int lat);
      lat = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (irq_of(sel) === 1'b1) begin
            lat = cyc - e0;
            break;
         end
      end
   endtask

   // Number of cycles in an n-cycle window where the interrupt is not 0.
   task automatic window(input bit sel, input int n, output int hits);
      hits = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (irq_of(sel) !== 1'b0) hits++;
      end
   endtask

   initial begin
      int e0, e1, lat, hits;
      reset = 1'b1; nwr = 1'b1; value = '0; interrupt_clear = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      expect_val("reset_irq4", 0); check_next(int'(irq4));
      expect_val("reset_irq1", 0); check_next(int'(irq1));
      reset = 1'b0;
      expect_val("idle_100", 0); window(0, 100, hits); check_next(hits);

      // Load 3 with M=4: the interrupt rises 12 edges later and holds.
      load(16'd3, 1, e0);
      expect_val("lat_3x4", 12); wait_rise(0, e0, 40, lat); check_next(lat);
      expect_val("hold_high", 5); window(0, 5, hits); check_next(hits);
      // A single-cycle acknowledge drops the interrupt, and it stays low.
      interrupt_clear = 1'b1;
      @(negedge clk);
      interrupt_clear = 1'b0;
      expect_val("clr_falls", 0); check_next(int'(irq4));
      expect_val("clr_stays", 0); window(0, 30, hits); check_next(hits);

      // Load 5, then reload 2 at edge 8: the reload aborts the first delay.
      load(16'd5, 1, e0);
      repeat (7) @(negedge clk);
      load(16'd2, 1, e1);
      expect_val("reload_lat", 8); wait_rise(0, e1, 40, lat); check_next(lat);

      // A load of 0 clears the pending flag and never raises the interrupt.
      load(16'd0, 1, e0);
      expect_val("zero_irq4", 0); window(0, 1000, hits); check_next(hits);
      expect_val("zero_irq1", 0); window(1, 10, hits); check_next(hits);

      // An acknowledge held high does not block the expiry, which wins on
      // its own edge. The clear then takes effect on the next edge.
      interrupt_clear = 1'b1;
      load(16'd1, 1, e0);
      expect_val("clr_held_lat", 4); wait_rise(0, e0, 20, lat); check_next(lat);
      @(negedge clk);
      expect_val("clr_held_fall", 0); check_next(int'(irq4));
      interrupt_clear = 1'b0;

      // A reset at edge 6 of a 3 us delay aborts the delay.
      load(16'd3, 1, e0);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      expect_val("reset_abort", 0); window(0, 40, hits); check_next(hits);

      // Holding nwr low for 3 edges: timing counts from the last low edge.
      load(16'd2, 3, e0);
      expect_val("held_nwr_lat", 8); wait_rise(0, e0, 40, lat); check_next(lat);

      // Maximum count with M=1: every running edge is a tick.
      load(16'hFFFF, 1, e0);
      expect_val("load_clears", 0); check_next(int'(irq1));
      expect_val("max_lat_m1", 65535); wait_rise(1, e0, 70000, lat); check_next(lat);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
